// File: rtl/ras_ckpt_if.sv
// Bus bundle for the checkpointed return address stack: request side
// (flush/push/pop/checkpoint control) and the registered status side.
interface ras_ckpt_if #(
    parameter int DEPTH    = 8,
    parameter int XLEN     = 64,
    parameter int NUM_CKPT = 4
);
    localparam int IW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic            flush_i;
    logic            push_i;
    logic            pop_i;
    logic [XLEN-1:0] data_i;
    logic            ckpt_save_i;
    logic [IW-1:0]   ckpt_save_id_i;
    logic            ckpt_restore_i;
    logic [IW-1:0]   ckpt_restore_id_i;
    logic [XLEN-1:0] top_ra_o;
    logic            top_valid_o;
    logic [CW-1:0]   count_o;
    logic            overflow_o;
    logic            underflow_o;

    modport master (
        output flush_i, push_i, pop_i, data_i,
        output ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i,
        input  top_ra_o, top_valid_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, data_i,
        input  ckpt_save_i, ckpt_save_id_i, ckpt_restore_i, ckpt_restore_id_i,
        output top_ra_o, top_valid_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ras_ckpt.sv
// Circular-buffer return address stack with a bank of checkpoints used to
// roll the stack back after a branch misprediction. Oldest entries are
// overwritten on overflow; all outputs come straight from registered state.
module ras_ckpt #(
    parameter int DEPTH    = 8,
    parameter int XLEN     = 64,
    parameter int NUM_CKPT = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    ras_ckpt_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1;

    logic [XLEN-1:0] mem_q    [DEPTH];
    logic [XLEN-1:0] mem_d    [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ck_ptr_q [NUM_CKPT];
    logic [PW-1:0]   ck_ptr_d [NUM_CKPT];
    logic [CW-1:0]   ck_cnt_q [NUM_CKPT];
    logic [CW-1:0]   ck_cnt_d [NUM_CKPT];
    logic [XLEN-1:0] ck_ra_q  [NUM_CKPT];
    logic [XLEN-1:0] ck_ra_d  [NUM_CKPT];
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            restore_ok;
    logic            save_ok;

    // Next-state: flush beats restore beats push/pop; the checkpoint save
    // then snapshots the resulting next state.
    always_comb begin
        mem_d      = mem_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        ck_ptr_d   = ck_ptr_q;
        ck_cnt_d   = ck_cnt_q;
        ck_ra_d    = ck_ra_q;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        restore_ok = {1'b0, bus.ckpt_restore_id_i} < (IW+1)'(NUM_CKPT);
        save_ok    = {1'b0, bus.ckpt_save_id_i} < (IW+1)'(NUM_CKPT);

        if (bus.flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (bus.ckpt_restore_i) begin
            // An out-of-range id restores nothing but still swallows push/pop.
            if (restore_ok) begin
                ptr_d        = ck_ptr_q[bus.ckpt_restore_id_i];
                cnt_d        = ck_cnt_q[bus.ckpt_restore_id_i];
                mem_d[ptr_d] = ck_ra_q[bus.ckpt_restore_id_i];
            end
        end else if (bus.push_i && bus.pop_i && (cnt_q != '0)) begin
            // Return followed by a call: replace the top entry in place.
            mem_d[ptr_q] = bus.data_i;
        end else if (bus.push_i) begin
            ptr_d        = ptr_q + PW'(1);
            mem_d[ptr_d] = bus.data_i;
            if (cnt_q == CW'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (bus.pop_i) begin
            if (cnt_q != '0) begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end

        if (bus.ckpt_save_i && save_ok) begin
            ck_ptr_d[bus.ckpt_save_id_i] = ptr_d;
            ck_cnt_d[bus.ckpt_save_id_i] = cnt_d;
            ck_ra_d[bus.ckpt_save_id_i]  = mem_d[ptr_d];
        end
    end

    // State register with asynchronous clear of the whole stack and bank.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int j = 0; j < NUM_CKPT; j++) begin
                ck_ptr_q[j] <= '0;
                ck_cnt_q[j] <= '0;
                ck_ra_q[j]  <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            ck_ptr_q <= ck_ptr_d;
            ck_cnt_q <= ck_cnt_d;
            ck_ra_q  <= ck_ra_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.top_ra_o    = (cnt_q != '0) ? mem_q[ptr_q] : '0;
    assign bus.top_valid_o = (cnt_q != '0);
    assign bus.count_o     = cnt_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: directed vector table, hand-written reset/checkpoint
// sequences, then random traffic against a behavioural stack model.
module tb_ras_ckpt;
    localparam int DEPTH    = 4;
    localparam int XLEN     = 32;
    localparam int NUM_CKPT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ras_ckpt_if #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_CKPT(NUM_CKPT)) bus ();

    ras_ckpt #(.DEPTH(DEPTH), .XLEN(XLEN), .NUM_CKPT(NUM_CKPT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        flush, push, pop;
        logic [31:0] data;
        logic        save;
        logic [1:0]  sid;
        logic        rest;
        logic [1:0]  rid;
        logic [31:0] e_top;
        int          e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t tbl[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference: stack slots addressed by a circular index.
    logic [31:0] m_mem [DEPTH];
    int          m_ptr, m_cnt;
    int          m_ckp [NUM_CKPT];
    int          m_ckc [NUM_CKPT];
    logic [31:0] m_ckr [NUM_CKPT];
    logic        m_ovf, m_unf;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            m_ckp[i] = 0; m_ckc[i] = 0; m_ckr[i] = 0;
        end
        m_ptr = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic model_step(input logic f, pu, po, input logic [31:0] d,
                              input logic sv, input int sid, input logic rs, input int rid);
        m_ovf = 0;
        m_unf = 0;
        if (f) begin
            m_ptr = 0; m_cnt = 0;
        end else if (rs) begin
            if (rid < NUM_CKPT) begin
                m_ptr = m_ckp[rid];
                m_cnt = m_ckc[rid];
                m_mem[m_ptr] = m_ckr[rid];
            end
        end else if (pu && po && m_cnt > 0) begin
            m_mem[m_ptr] = d;
        end else if (pu) begin
            if (m_cnt == DEPTH) m_ovf = 1;
            else m_cnt = m_cnt + 1;
            m_ptr = (m_ptr + 1) % DEPTH;
            m_mem[m_ptr] = d;
        end else if (po) begin
            if (m_cnt > 0) begin
                m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                m_cnt = m_cnt - 1;
            end else begin
                m_unf = 1;
            end
        end
        if (sv && sid < NUM_CKPT) begin
            m_ckp[sid] = m_ptr;
            m_ckc[sid] = m_cnt;
            m_ckr[sid] = m_mem[m_ptr];
        end
    endtask

    function automatic logic [31:0] model_top();
        return (m_cnt != 0) ? m_mem[m_ptr] : 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] e_top, input int e_cnt,
                                 input logic e_ovf, input logic e_unf);
        check({tag, ".top"},   bus.top_ra_o, e_top);
        check({tag, ".cnt"},   32'(bus.count_o), 32'(e_cnt));
        check({tag, ".valid"}, 32'(bus.top_valid_o), 32'(e_cnt != 0));
        check({tag, ".ovf"},   32'(bus.overflow_o), 32'(e_ovf));
        check({tag, ".unf"},   32'(bus.underflow_o), 32'(e_unf));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, settle.
    task automatic cycle(input logic f, pu, po, input logic [31:0] d,
                         input logic sv, input logic [1:0] sid, input logic rs, input logic [1:0] rid);
        bus.flush_i = f; bus.push_i = pu; bus.pop_i = po; bus.data_i = d;
        bus.ckpt_save_i = sv; bus.ckpt_save_id_i = sid;
        bus.ckpt_restore_i = rs; bus.ckpt_restore_id_i = rid;
        @(posedge clk);
        model_step(f, pu, po, d, sv, int'(sid), rs, int'(rid));
        #1;
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0;
        bus.ckpt_save_i = 0; bus.ckpt_restore_i = 0;
    endtask

    task automatic add(input logic f, pu, po, input logic [31:0] d, input logic sv,
                       input logic [1:0] sid, input logic rs, input logic [1:0] rid,
                       input logic [31:0] et, input int ec, input logic eo, input logic eu);
        vec_t v;
        v.flush = f; v.push = pu; v.pop = po; v.data = d; v.save = sv; v.sid = sid;
        v.rest = rs; v.rid = rid; v.e_top = et; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
        tbl.push_back(v);
    endtask

    localparam logic [31:0] A = 32'h100, B = 32'h200, C = 32'h300, D = 32'h400;
    localparam logic [31:0] X = 32'h900, Y = 32'hA00, E = 32'hE00;

    initial begin
        bus.flush_i = 0; bus.push_i = 0; bus.pop_i = 0; bus.data_i = 0;
        bus.ckpt_save_i = 0; bus.ckpt_save_id_i = 0;
        bus.ckpt_restore_i = 0; bus.ckpt_restore_id_i = 0;
        model_reset();

        //   f  pu po data  sv sid rs rid  top  cnt ovf unf
        // push three, pop three
        add(0, 1, 0, A,     0, 0, 0, 0,    A,   1,  0,  0);
        add(0, 1, 0, B,     0, 0, 0, 0,    B,   2,  0,  0);
        add(0, 1, 0, C,     0, 0, 0, 0,    C,   3,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    B,   2,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    A,   1,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    0,   0,  0,  0);
        // overflow and underflow
        add(0, 1, 0, 32'h11, 0, 0, 0, 0,   32'h11, 1, 0, 0);
        add(0, 1, 0, 32'h12, 0, 0, 0, 0,   32'h12, 2, 0, 0);
        add(0, 1, 0, 32'h13, 0, 0, 0, 0,   32'h13, 3, 0, 0);
        add(0, 1, 0, 32'h14, 0, 0, 0, 0,   32'h14, 4, 0, 0);
        add(0, 1, 0, 32'h15, 0, 0, 0, 0,   32'h15, 4, 1, 0);
        add(0, 0, 1, 0,      0, 0, 0, 0,   32'h14, 3, 0, 0);
        add(0, 0, 1, 0,      0, 0, 0, 0,   32'h13, 2, 0, 0);
        add(0, 0, 1, 0,      0, 0, 0, 0,   32'h12, 1, 0, 0);
        add(0, 0, 1, 0,      0, 0, 0, 0,   0,      0, 0, 0);
        add(0, 0, 1, 0,      0, 0, 0, 0,   0,      0, 0, 1);
        add(0, 0, 0, 0,      0, 0, 0, 0,   0,      0, 0, 0);
        // simultaneous push+pop
        add(0, 1, 0, A,     0, 0, 0, 0,    A,   1,  0,  0);
        add(0, 1, 1, B,     0, 0, 0, 0,    B,   1,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    0,   0,  0,  0);
        add(0, 1, 1, C,     0, 0, 0, 0,    C,   1,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    0,   0,  0,  0);
        // checkpoint save / restore
        add(0, 1, 0, A,     0, 0, 0, 0,    A,   1,  0,  0);
        add(0, 1, 0, B,     0, 0, 0, 0,    B,   2,  0,  0);
        add(0, 0, 0, 0,     1, 2, 0, 0,    B,   2,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    A,   1,  0,  0);
        add(0, 1, 0, X,     0, 0, 0, 0,    X,   2,  0,  0);
        add(0, 1, 0, Y,     0, 0, 0, 0,    Y,   3,  0,  0);
        add(0, 0, 0, 0,     0, 0, 1, 2,    B,   2,  0,  0);
        add(0, 0, 1, 0,     0, 0, 0, 0,    A,   1,  0,  0);
        add(1, 0, 0, 0,     0, 0, 0, 0,    0,   0,  0,  0);
        // priority between flush, restore and push
        add(0, 1, 0, A,     1, 1, 0, 0,    A,   1,  0,  0);
        add(0, 1, 0, B,     0, 0, 0, 0,    B,   2,  0,  0);
        add(1, 1, 0, D,     0, 0, 1, 1,    0,   0,  0,  0);
        add(0, 1, 0, D,     0, 0, 1, 1,    A,   1,  0,  0);
        add(0, 1, 0, C,     0, 0, 0, 0,    C,   2,  0,  0);
        add(0, 0, 0, 0,     1, 1, 1, 1,    A,   1,  0,  0);
        add(0, 1, 0, D,     0, 0, 0, 0,    D,   2,  0,  0);
        add(0, 0, 0, 0,     0, 0, 1, 1,    A,   1,  0,  0);
        // out-of-range ids
        add(0, 1, 0, E,     0, 0, 0, 0,    E,   2,  0,  0);
        add(0, 1, 0, D,     0, 0, 1, 3,    E,   2,  0,  0);
        add(0, 0, 1, 0,     1, 3, 0, 0,    A,   1,  0,  0);
        add(0, 0, 0, 0,     0, 0, 1, 1,    A,   1,  0,  0);

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check_outputs("reset", 0, 0, 0, 0);

        foreach (tbl[i]) begin
            cycle(tbl[i].flush, tbl[i].push, tbl[i].pop, tbl[i].data,
                  tbl[i].save, tbl[i].sid, tbl[i].rest, tbl[i].rid);
            check_outputs($sformatf("tbl[%0d]", i), tbl[i].e_top, tbl[i].e_cnt,
                          tbl[i].e_ovf, tbl[i].e_unf);
        end

        // Asynchronous reset with three entries live and a save pending
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, A, 0, 0, 0, 0);
        cycle(0, 1, 0, B, 0, 0, 0, 0);
        cycle(0, 1, 0, C, 1, 0, 0, 0);
        check_outputs("pre_rst", C, 3, 0, 0);
        bus.ckpt_save_i = 1; bus.ckpt_save_id_i = 2;
        #2 rst = 1;
        #1 check_outputs("async_rst", 0, 0, 0, 0);
        bus.ckpt_save_i = 0;
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int s = 0; s < NUM_CKPT; s++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, 2'(s));
            check_outputs($sformatf("rst_restore%0d", s), 0, 0, 0, 0);
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic f, pu, po, sv, rs;
            f  = ($urandom_range(31) == 0);
            rs = ($urandom_range(7) == 0);
            sv = ($urandom_range(5) == 0);
            pu = $urandom_range(1);
            po = $urandom_range(1);
            cycle(f, pu, po, $urandom, sv, 2'($urandom_range(3)), rs, 2'($urandom_range(3)));
            check_outputs($sformatf("rnd[%0d]", n), model_top(), m_cnt, m_ovf, m_unf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
